// File: rtl/memwb_pkg.sv
// memwb_pkg: shared widths, occupancy encoding and payload layout for the MEM/WB skid stage.
package memwb_pkg;

   localparam int ADDR_W_DEF = 64;
   localparam int DATA_W_DEF = 64;
   localparam int REG_W_DEF  = 5;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_state_t;

   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Layout at default widths; the stage rebuilds it locally for its own parameters.
   typedef struct packed {
      logic [ADDR_W_DEF-1:0]                         mem_address;
      logic [DATA_W_DEF-1:0]                         mem_data;
      logic [REG_W_DEF-1:0]                          write_reg;
      logic                                          regwrite;
      logic                                          mem2reg;
      logic [max_w(ADDR_W_DEF, DATA_W_DEF)-1:0]      wb_data;
   } memwb_payload_t;

endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: generic 2-entry valid/ready buffer with registered in_ready and synchronous flush.
module skid_buffer
   import memwb_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   occupancy
);

   occ_state_t   state_q, state_d;
   logic [W-1:0] main_q, main_d, skid_q, skid_d;
   logic         in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic         accept, pop;

   assign accept = in_valid & in_ready_q;
   assign pop    = out_valid_q & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         OCC_EMPTY: begin
            state_d = accept ? OCC_ONE : OCC_EMPTY;
            main_d  = accept ? in_data : main_q;
         end
         OCC_ONE: begin
            state_d = (accept & !pop) ? OCC_TWO : (pop & !accept) ? OCC_EMPTY : OCC_ONE;
            main_d  = (accept & pop) ? in_data : main_q;
            skid_d  = (accept & !pop) ? in_data : skid_q;
         end
         OCC_TWO: begin
            state_d = pop ? OCC_ONE : OCC_TWO;
            main_d  = pop ? skid_q : main_q;
         end
         default: state_d = OCC_EMPTY;
      endcase
      // Flush empties the buffer but leaves payload registers stale.
      if (flush) begin
         state_d = OCC_EMPTY;
         main_d  = main_q;
         skid_d  = skid_q;
      end
      in_ready_d  = (state_d != OCC_TWO);
      out_valid_d = (state_d != OCC_EMPTY);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= OCC_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;
   assign occupancy = state_q;

endmodule

// File: rtl/memwb_skid_stage.sv
// memwb_skid_stage: MEM/WB pipeline stage with valid/ready handshake, 2-entry skid buffer,
// precomputed writeback data, flush and a saturating bubble counter.
module memwb_skid_stage
   import memwb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_W  = REG_W_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   localparam int WB_W  = max_w(ADDR_W, DATA_W)
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] mem_address_in,
   input  logic [DATA_W-1:0] mem_data_in,
   input  logic [REG_W-1:0]  write_reg_in,
   input  logic              regwrite_in,
   input  logic              mem2reg_in,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] mem_address_out,
   output logic [DATA_W-1:0] mem_data_out,
   output logic [REG_W-1:0]  write_reg_out,
   output logic              regwrite_out,
   output logic              mem2reg_out,
   output logic [WB_W-1:0]   wb_data_out,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  bubble_count
);

   typedef struct packed {
      logic [ADDR_W-1:0] mem_address;
      logic [DATA_W-1:0] mem_data;
      logic [REG_W-1:0]  write_reg;
      logic              regwrite;
      logic              mem2reg;
      logic [WB_W-1:0]   wb_data;
   } payload_t;

   payload_t         in_pl, head;
   logic [CNT_W-1:0] bubble_q, bubble_d;

   always_comb begin
      in_pl.mem_address = mem_address_in;
      in_pl.mem_data    = mem_data_in;
      in_pl.write_reg   = write_reg_in;
      in_pl.regwrite    = regwrite_in;
      in_pl.mem2reg     = mem2reg_in;
      in_pl.wb_data     = mem2reg_in ? WB_W'(mem_data_in) : WB_W'(mem_address_in);
   end

   skid_buffer #(.W($bits(payload_t))) u_buf (
      .clk       (CLOCK),
      .rst       (RESET),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_pl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head),
      .occupancy (occupancy)
   );

   always_comb begin
      bubble_d = (!out_valid && bubble_q != '1) ? bubble_q + CNT_W'(1) : bubble_q;
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) bubble_q <= '0;
      else bubble_q <= bubble_d;
   end

   // Bubbles must never write the register file.
   assign regwrite_out    = head.regwrite & out_valid;
   assign mem_address_out = head.mem_address;
   assign mem_data_out    = head.mem_data;
   assign write_reg_out   = head.write_reg;
   assign mem2reg_out     = head.mem2reg;
   assign wb_data_out     = head.wb_data;
   assign bubble_count    = bubble_q;

endmodule

// File: tb/tb_memwb_skid_stage.sv
// tb_memwb_skid_stage: table-driven directed checks of handshake, skid, flush, reset and bubble counter.
module tb_memwb_skid_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, regwrite_in = 1'b0, mem2reg_in = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic [63:0] addr_in = '0, data_in = '0;
   logic [4:0]  reg_in = '0;
   logic        in_ready, out_valid, regwrite_out, mem2reg_out;
   logic [63:0] addr_out, data_out, wb_out;
   logic [4:0]  reg_out;
   logic [1:0]  occ;
   logic [15:0] bubble;
   logic        x_in_ready, x_out_valid, x_regwrite_out, x_mem2reg_out;
   logic [63:0] x_addr_out, x_data_out, x_wb_out;
   logic [4:0]  x_reg_out;
   logic [1:0]  x_occ;
   logic [2:0]  x_bubble;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   memwb_skid_stage dut (
      .CLOCK(clk), .RESET(rst), .in_valid(in_valid), .in_ready(in_ready),
      .mem_address_in(addr_in), .mem_data_in(data_in), .write_reg_in(reg_in),
      .regwrite_in(regwrite_in), .mem2reg_in(mem2reg_in), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .mem_address_out(addr_out),
      .mem_data_out(data_out), .write_reg_out(reg_out), .regwrite_out(regwrite_out),
      .mem2reg_out(mem2reg_out), .wb_data_out(wb_out), .occupancy(occ), .bubble_count(bubble)
   );

   memwb_skid_stage #(.CNT_W(3)) dut3 (
      .CLOCK(clk), .RESET(rst), .in_valid(in_valid), .in_ready(x_in_ready),
      .mem_address_in(addr_in), .mem_data_in(data_in), .write_reg_in(reg_in),
      .regwrite_in(regwrite_in), .mem2reg_in(mem2reg_in), .flush(flush),
      .out_valid(x_out_valid), .out_ready(out_ready), .mem_address_out(x_addr_out),
      .mem_data_out(x_data_out), .write_reg_out(x_reg_out), .regwrite_out(x_regwrite_out),
      .mem2reg_out(x_mem2reg_out), .wb_data_out(x_wb_out), .occupancy(x_occ), .bubble_count(x_bubble)
   );

   typedef struct {
      logic        iv;
      logic [63:0] addr;
      logic [63:0] data;
      logic        rw;
      logic        m2r;
      logic        ordy;
      logic        fl;
      logic        e_ov;
      logic        e_ir;
      logic [1:0]  e_occ;
      logic [63:0] e_addr;
      logic [63:0] e_wb;
      logic        e_rw;
   } vec_t;

   vec_t vecs[19];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [63:0] a, input logic [63:0] d,
                        input logic rw, input logic m2r, input logic ordy, input logic fl);
      in_valid    = iv;
      addr_in     = a;
      data_in     = d;
      reg_in      = a[4:0];
      regwrite_in = rw;
      mem2reg_in  = m2r;
      out_ready   = ordy;
      flush       = fl;
   endtask

   initial begin
      vecs[0]  = '{1, 'h10, 'h110, 1, 0, 1, 0, 1, 1, 1, 'h10, 'h10, 1};
      vecs[1]  = '{1, 'h11, 'h111, 1, 0, 1, 0, 1, 1, 1, 'h11, 'h11, 1};
      vecs[2]  = '{1, 'h12, 'h112, 1, 0, 1, 0, 1, 1, 1, 'h12, 'h12, 1};
      vecs[3]  = '{1, 'h13, 'h113, 1, 0, 1, 0, 1, 1, 1, 'h13, 'h13, 1};
      vecs[4]  = '{0, 'h0,  'h0,   0, 0, 1, 0, 0, 1, 0, 'h13, 'h13, 0};
      vecs[5]  = '{1, 'h20, 'hDEAD, 1, 1, 0, 0, 1, 1, 1, 'h20, 'hDEAD, 1};
      vecs[6]  = '{1, 'h21, 'hBEEF, 0, 0, 0, 0, 1, 0, 2, 'h20, 'hDEAD, 1};
      vecs[7]  = '{1, 'h22, 'h1,   1, 1, 0, 0, 1, 0, 2, 'h20, 'hDEAD, 1};
      vecs[8]  = '{1, 'h22, 'h1,   1, 1, 1, 0, 1, 1, 1, 'h21, 'h21, 0};
      vecs[9]  = '{1, 'h22, 'h1,   1, 1, 1, 0, 1, 1, 1, 'h22, 'h1, 1};
      vecs[10] = '{0, 'h0,  'h0,   0, 0, 1, 0, 0, 1, 0, 'h22, 'h1, 0};
      vecs[11] = '{1, 'h30, 'h130, 1, 0, 0, 0, 1, 1, 1, 'h30, 'h30, 1};
      vecs[12] = '{1, 'h31, 'h131, 1, 0, 0, 0, 1, 0, 2, 'h30, 'h30, 1};
      vecs[13] = '{1, 'h32, 'h132, 1, 0, 0, 1, 0, 1, 0, 'h30, 'h30, 0};
      vecs[14] = '{0, 'h0,  'h0,   0, 0, 1, 0, 0, 1, 0, 'h30, 'h30, 0};
      vecs[15] = '{1, 'h40, 'h140, 1, 0, 1, 0, 1, 1, 1, 'h40, 'h40, 1};
      vecs[16] = '{0, 'h0,  'h0,   0, 0, 1, 0, 0, 1, 0, 'h40, 'h40, 0};
      vecs[17] = '{1, 'h50, 'h150, 1, 0, 0, 0, 1, 1, 1, 'h50, 'h50, 1};
      vecs[18] = '{1, 'h51, 'h151, 1, 0, 1, 1, 0, 1, 0, 'h50, 'h50, 0};

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) step();
      chk("idle_out_valid", out_valid, 0);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_regwrite", regwrite_out, 0);
      chk("idle_occ", occ, 0);
      chk("idle_wb", wb_out, 0);
      chk("idle_bubble5", bubble, 5);
      chk("idle_bubble5_cnt3", x_bubble, 5);
      repeat (5) step();
      chk("idle_bubble10", bubble, 10);
      chk("bubble_saturate_cnt3", x_bubble, 7);

      for (int i = 0; i < 19; i++) begin
         drive(vecs[i].iv, vecs[i].addr, vecs[i].data, vecs[i].rw, vecs[i].m2r, vecs[i].ordy, vecs[i].fl);
         step();
         chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
         chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
         chk($sformatf("v%0d_occ", i), occ, vecs[i].e_occ);
         chk($sformatf("v%0d_addr", i), addr_out, vecs[i].e_addr);
         chk($sformatf("v%0d_reg", i), reg_out, vecs[i].e_addr[4:0]);
         chk($sformatf("v%0d_wb", i), wb_out, vecs[i].e_wb);
         chk($sformatf("v%0d_regwrite", i), regwrite_out, vecs[i].e_rw);
      end
      chk("bubble_after_table", bubble, 16);

      drive(1, 'h60, 'h160, 1, 0, 1, 0);
      step();
      chk("pre_reset_valid", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_ready", in_ready, 1);
      chk("async_rst_occ", occ, 0);
      chk("async_rst_addr", addr_out, 0);
      chk("async_rst_data", data_out, 0);
      chk("async_rst_wb", wb_out, 0);
      chk("async_rst_regwrite", regwrite_out, 0);
      chk("async_rst_bubble", bubble, 0);
      #2 rst = 1'b0;
      drive(1, 'h70, 'h77, 1, 1, 1, 0);
      step();
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_addr", addr_out, 'h70);
      chk("post_rst_data", data_out, 'h77);
      chk("post_rst_wb", wb_out, 'h77);
      chk("post_rst_m2r", mem2reg_out, 1);
      chk("post_rst_regwrite", regwrite_out, 1);
      drive(0, 'h0, 'h0, 0, 0, 1, 0);
      step();
      chk("post_rst_drain", out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/memwb_skid_stage.md
Name: memwb_skid_stage

Overview:
- Parametrised successor to the MEM/WB pipeline latch.
- Sits between the memory-access stage and register-file writeback.
- Adds a valid/ready handshake, a 2-entry skid buffer (registered in_ready), a synchronous flush, a pre-computed writeback-data mux and a saturating bubble counter.
- Bubbles can never cause a register write, because regwrite_out is gated by out_valid.

Parameters:
- ADDR_W, 64, width of ALU result / memory address field.
- DATA_W, 64, width of memory read-data field.
- REG_W, 5, width of destination register index.
- CNT_W, 16, width of bubble counter.

Ports:
- CLOCK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept; registered.
- mem_address_in  in  ADDR_W  ALU result / address.
- mem_data_in  in  DATA_W  memory read data.
- write_reg_in  in  REG_W  destination register.
- regwrite_in  in  1  instruction writes register file.
- mem2reg_in  in  1  writeback selects memory data.
- flush  in  1  discard all held and incoming entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  writeback consumes head.
- mem_address_out  out  ADDR_W  head field.
- mem_data_out  out  DATA_W  head field.
- write_reg_out  out  REG_W  head field.
- regwrite_out  out  1  head regwrite AND out_valid.
- mem2reg_out  out  1  head field.
- wb_data_out  out  max(ADDR_W,DATA_W)  mem2reg ? mem_data : mem_address, zero-extended.
- occupancy  out  2  entries held: 0, 1 or 2.
- bubble_count  out  CNT_W  cycles with out_valid=0 since reset.

Behaviour:
- Handshake events:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
- All outputs are registered; no combinational in->out path.
- Storage:
  - Head register (main) drives the *_out ports.
  - Skid register holds a second entry.
- Payload: {mem_address, mem_data, write_reg, regwrite, mem2reg, wb_data}. wb_data is computed from the inputs at load time.
- State (occupancy) is one of EMPTY, ONE, TWO; in_ready = (state != TWO), registered.
- Transitions, evaluated each rising edge when flush=0:
  - EMPTY: accept -> ONE, main<=in.
  - ONE: accept & !pop -> TWO, skid<=in.
  - ONE: pop & !accept -> EMPTY.
  - ONE: accept & pop -> ONE, main<=in.
  - ONE: neither -> hold.
  - TWO: pop -> ONE, main<=skid. accept is impossible because in_ready=0.
  - TWO: !pop -> hold.
- out_valid = (state != EMPTY).
- Latency: an entry accepted in cycle N is visible on *_out in N+1 if the buffer was empty or popping.
- Throughput: 1 entry/cycle while out_ready=1.
- Flush:
  - Highest priority; next state is EMPTY and in_ready=1.
  - Any same-cycle accept is discarded; a same-cycle pop still counts as consumed by downstream.
  - Payload registers keep stale data.
  - regwrite_out is forced to 0 whenever out_valid=0.
- Reset (any time, including mid-transfer, asynchronous):
  - state=EMPTY, in_ready=1, out_valid=0.
  - All payload outputs 0, regwrite_out=0, wb_data_out=0.
  - occupancy=0, bubble_count=0.
- bubble_count:
  - Increments on each edge where out_valid=0 at that edge.
  - Saturates at 2^CNT_W-1; does not wrap.
  - Flush does not clear it.
- Skid entry must never be lost or reordered: output order equals accept order.

Decomposition:
- Package memwb_pkg holds:
  - Parameter defaults.
  - Packed payload struct memwb_payload_t.
  - Occupancy encoding constants OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2.
- Sub-module skid_buffer: generic 2-entry valid/ready buffer parametrised on payload width, with flush.
- memwb_skid_stage wraps skid_buffer and adds:
  - wb_data mux at the input.
  - regwrite gating at the output.
  - Bubble counter.

Test Plan:
- Reset then idle 5 cycles -> out_valid=0, in_ready=1, regwrite_out=0, bubble_count=5.
- Stream 4 entries with out_ready=1 (addr 0x10..0x13, mem2reg=0) -> outputs appear one cycle later in order; wb_data_out=0x10..0x13; occupancy stays 1.
- Accept A (mem2reg=1, data 0xDEAD); hold out_ready=0; accept B; try C -> in_ready drops to 0 after B; occupancy=2; C is not accepted. Raise out_ready -> A (wb_data=0xDEAD) then B, then C accepted.
- TWO state, assert flush with in_valid=1 -> next cycle out_valid=0, regwrite_out=0, occupancy=0, in_ready=1; flushed entries never reappear.
- Assert RESET asynchronously mid-stream between edges -> outputs clear immediately without a clock edge; after deassert the first new entry is output correctly.
- CNT_W=3 with 10 idle cycles -> bubble_count saturates at 7.
